// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the arbiter and the
// UART TX core. The arbiter takes the slave view; the producers and the core
// together take the master view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   reqValid;
  logic [8*NUM_REQ-1:0] reqData;
  logic [NUM_REQ-1:0]   reqLast;
  logic [NUM_REQ-1:0]   reqReady;
  logic [7:0]           txData;
  logic                 txValid;
  logic                 txBusy;
  logic [NUM_REQ-1:0]   grant;

  modport master (
    output reqValid, reqData, reqLast, txBusy,
    input  reqReady, txData, txValid, grant
  );

  modport slave (
    input  reqValid, reqData, reqLast, txBusy,
    output reqReady, txData, txValid, grant
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte streams.
// Round-robin grant, locked to the winner until reqLast or MAX_BURST bytes.
// Optional FETCH stall timeout: define UART_TX_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin from rrPtr
// FETCH | owner k holds the grant; reqReady[k] follows reqValid[k]
// SEND  | holdBuf on txData with txValid=1 until the core takes it
// WAIT  | core busy with the byte; then release or fetch the next byte
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [NUM_REQ-1:0] GRANT_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t             state;
  logic [NUM_REQ-1:0] grantQ;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      rrPtr;
  logic [BW-1:0]      burstCnt;
  logic [7:0]         holdBuf;
  logic               holdLast;
  logic               txValidQ;

  logic               found;
  logic [PW-1:0]      winIdx;
  logic [PW-1:0]      cand;
  logic               ownerValid;
  logic [7:0]         ownerData;
  logic               ownerLast;
  logic               burstDone;
  logic [PW-1:0]      nextPtr;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TW-1:0] stallCnt;
  logic          stallExpire;
  // the expiring cycle is the TIMEOUT_CYCLES-th stalled one, so compare one early
  assign stallExpire = (stallCnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Round-robin search: first valid requester at or after rrPtr, with wrap.
  always_comb begin
    found  = 1'b0;
    winIdx = '0;
    cand   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = PW'((int'(rrPtr) + off) % NUM_REQ);
      if (!found && bus.reqValid[cand]) begin
        found  = 1'b1;
        winIdx = cand;
      end
    end
  end

  assign ownerValid = bus.reqValid[owner];
  assign ownerData  = bus.reqData[{owner, 3'b000} +: 8];
  assign ownerLast  = bus.reqLast[owner];
  assign burstDone  = (MAX_BURST != 0) && (burstCnt == BW'(MAX_BURST));
  assign nextPtr    = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);

  // Only the owner sees ready, and only while a byte is being fetched.
  assign bus.reqReady = (state == FETCH) ? (grantQ & bus.reqValid) : '0;
  assign bus.grant    = grantQ;
  assign bus.txValid  = txValidQ;
  assign bus.txData   = holdBuf;

  // Arbitration and byte-forwarding state machine with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grantQ   <= '0;
      owner    <= '0;
      rrPtr    <= '0;
      burstCnt <= '0;
      holdBuf  <= '0;
      holdLast <= 1'b0;
      txValidQ <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      stallCnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grantQ   <= GRANT_ONE << winIdx;
            owner    <= winIdx;
            burstCnt <= '0;
            state    <= FETCH;
`ifdef UART_TX_ARB_TIMEOUT_EN
            stallCnt <= '0;
`endif
          end
        end

        FETCH: begin
          if (ownerValid) begin
            holdBuf  <= ownerData;
            holdLast <= ownerLast;
            if (MAX_BURST != 0) burstCnt <= burstCnt + BW'(1);
            txValidQ <= 1'b1;
            state    <= SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
            stallCnt <= '0;
`endif
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (stallExpire) begin
            grantQ   <= '0;
            rrPtr    <= nextPtr;
            stallCnt <= '0;
            state    <= IDLE;
          end else begin
            stallCnt <= stallCnt + TW'(1);
          end
`endif
        end

        SEND: begin
          // txData stays put while the core is still busy with a previous byte
          if (!bus.txBusy) begin
            txValidQ <= 1'b0;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (!bus.txBusy) begin
            if (holdLast || burstDone) begin
              grantQ <= '0;
              rrPtr  <= nextPtr;
              state  <= IDLE;
            end else begin
              state <= FETCH;
`ifdef UART_TX_ARB_TIMEOUT_EN
              stallCnt <= '0;
`endif
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: reference model of the arbitration rules,
// requester queues, a UART core stand-in, directed cases and a random run.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 2;
  localparam int TO = 8;
  localparam int P_IDLE = 0, P_FETCH = 1, P_SEND = 2, P_WAIT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit [7:0] qd[N][$];
  bit       ql[N][$];
  bit [7:0] exp_d[N][$];
  bit       rnd_mode = 0;
  bit       rnd_busy = 0;
  int       busy_len = 1;
  int       busy_left = 0;
  int       log_id[$];
  bit [7:0] log_d[$];

  int       m_ph, m_own, m_rr, m_cnt, m_stall;
  bit       m_last;
  bit [7:0] m_hold;

  logic [N-1:0] xfer_s;
  bit           wa_s;
  int           wa_id;
  bit [7:0]     wa_d;

  int c_rdy0, c_txv, c_g1, c_stall;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int off = 0; off < N; off++)
      if (v[(rr + off) % N]) return (rr + off) % N;
    return -1;
  endfunction

  task automatic m_release();
    m_rr  = (m_own + 1) % N;
    m_own = -1;
    m_ph  = P_IDLE;
  endtask

  task automatic clear_counters();
    c_rdy0 = 0; c_txv = 0; c_g1 = 0; c_stall = 0;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      qd[i].delete();
      ql[i].delete();
    end
  endtask

  // One clock: compare and advance the model at negedge, then drive the core
  // and the requesters 1 time unit after posedge.
  task automatic step();
    logic [N-1:0]   v, l, eg, one;
    logic [8*N-1:0] d;
    @(negedge clk);
    v = bus.reqValid; d = bus.reqData; l = bus.reqLast;
    one = 1;
    if (reset) begin
      m_ph = P_IDLE; m_own = -1; m_rr = 0; m_cnt = 0; m_stall = 0;
      m_last = 0; m_hold = 0;
      xfer_s = '0; wa_s = 0;
    end else begin
      eg = (m_own >= 0) ? (one << m_own) : '0;
      chk("grant", bus.grant, eg);
      chk("reqReady", bus.reqReady, (m_ph == P_FETCH) ? (v & eg) : '0);
      chk("txValid", bus.txValid, m_ph == P_SEND);
      if (m_ph == P_SEND) chk("txData", bus.txData, m_hold);

      if (bus.reqReady[0]) c_rdy0++;
      if (bus.txValid) c_txv++;
      if (bus.grant == 4'b0001) c_g1++;
      if (bus.grant == 4'b0100 && !bus.reqValid[2] && !bus.txValid && !bus.txBusy) c_stall++;

      xfer_s = v & bus.reqReady;
      wa_s   = bus.txValid && !bus.txBusy;
      wa_id  = -1;
      for (int i = 0; i < N; i++) if (bus.grant[i]) wa_id = i;
      wa_d   = bus.txData;

      case (m_ph)
        P_IDLE: begin
          if (v != 0) begin
            m_own = pick(v, m_rr); m_cnt = 0; m_stall = 0; m_ph = P_FETCH;
          end
        end
        P_FETCH: begin
          if (v[m_own]) begin
            m_hold  = 8'(d >> (8 * m_own));
            m_last  = l[m_own];
            m_cnt   = m_cnt + 1;
            m_stall = 0;
            m_ph    = P_SEND;
          end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
            m_stall = m_stall + 1;
            if (m_stall == TO) m_release();
`endif
          end
        end
        P_SEND: if (!bus.txBusy) m_ph = P_WAIT;
        default: begin
          if (!bus.txBusy) begin
            if (m_last || (MB != 0 && m_cnt == MB)) m_release();
            else begin
              m_ph = P_FETCH; m_stall = 0;
            end
          end
        end
      endcase
    end

    @(posedge clk);
    #1;
    if (reset) begin
      bus.txBusy = 1'b0;
      busy_left  = 0;
    end else if (wa_s) begin
      bus.txBusy = 1'b1;
      busy_left  = rnd_busy ? int'($urandom_range(1, 4)) : busy_len;
      log_id.push_back(wa_id);
      log_d.push_back(wa_d);
    end else if (bus.txBusy) begin
      busy_left--;
      if (busy_left <= 0) bus.txBusy = 1'b0;
    end else if (rnd_busy && $urandom_range(0, 15) == 0) begin
      bus.txBusy = 1'b1;
      busy_left  = int'($urandom_range(1, 3));
    end

    for (int i = 0; i < N; i++) begin
      if (!reset && xfer_s[i] && qd[i].size() > 0) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
      if (reset || qd[i].size() == 0) begin
        bus.reqValid[i]       = 1'b0;
        bus.reqData[8*i +: 8] = 8'($urandom);
        bus.reqLast[i]        = 1'($urandom);
      end else begin
        bus.reqValid[i]       = rnd_mode ? ($urandom_range(0, 99) < 70) : 1'b1;
        bus.reqData[8*i +: 8] = qd[i][0];
        bus.reqLast[i]        = ql[i][0];
      end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic hard_reset();
    clear_queues();
    reset = 1'b1;
    steps(2);
    #1 reset = 1'b0;
  endtask

  task automatic push(input int r, input bit [7:0] b, input bit last);
    qd[r].push_back(b);
    ql[r].push_back(last);
  endtask

  task automatic wait_log(input int target, input int budget, input string name);
    int n = 0;
    while (log_id.size() < target && n < budget) begin
      step();
      n++;
    end
    chk(name, log_id.size(), target);
  endtask

  task automatic chk_log(input string name, input int idx, input int id, input bit [7:0] b);
    if (idx >= log_id.size()) chk(name, log_id.size(), idx + 1);
    else begin
      chk({name, " id"}, log_id[idx], id);
      chk({name, " data"}, log_d[idx], b);
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin : main
    int base, mism, seen, total;
    bit [7:0] b;
    int len;

    bus.reqValid = '0; bus.reqData = '0; bus.reqLast = '0; bus.txBusy = 1'b0;
    clear_counters();
    hard_reset();
    chk("reset grant", bus.grant, 0);
    chk("reset txValid", bus.txValid, 0);
    chk("reset txData", bus.txData, 0);
    chk("reset reqReady", bus.reqReady, 0);

    // single terminated byte, core busy 20 cycles
    busy_len = 20;
    base = log_id.size();
    clear_counters();
    push(0, 8'hA5, 1);
    steps(40);
    chk("t1 reqReady0 cycles", c_rdy0, 1);
    chk("t1 txValid cycles", c_txv, 1);
    // FETCH + SEND + 20 busy cycles + the WAIT cycle that sees busy low
    chk("t1 grant0001 cycles", c_g1, 23);
    chk("t1 grant end", bus.grant, 0);
    chk_log("t1 byte", base, 0, 8'hA5);

    // two requesters, req1 re-requests
    hard_reset();
    busy_len = 3;
    base = log_id.size();
    push(1, 8'h11, 1); push(1, 8'h13, 1); push(2, 8'h22, 1);
    wait_log(base + 3, 300, "t2 done");
    chk_log("t2 b0", base + 0, 1, 8'h11);
    chk_log("t2 b1", base + 1, 2, 8'h22);
    chk_log("t2 b2", base + 2, 1, 8'h13);

    // 3-byte message vs waiting req3; burst limit 2 splits it
    hard_reset();
    base = log_id.size();
    push(0, 8'h01, 0); push(0, 8'h02, 0); push(0, 8'h03, 1); push(3, 8'h33, 1);
    wait_log(base + 4, 300, "t3 done");
    chk_log("t3 b0", base + 0, 0, 8'h01);
    chk_log("t3 b1", base + 1, 0, 8'h02);
    chk_log("t3 b2", base + 2, 3, 8'h33);
    chk_log("t3 b3", base + 3, 0, 8'h03);

    // unterminated 5-byte stream, bursts of 2
    hard_reset();
    base = log_id.size();
    for (int i = 0; i < 5; i++) push(0, 8'hA0 + 8'(i), 0);
    push(1, 8'hB0, 1);
    wait_log(base + 6, 400, "t4 done");
    chk_log("t4 b0", base + 0, 0, 8'hA0);
    chk_log("t4 b1", base + 1, 0, 8'hA1);
    chk_log("t4 b2", base + 2, 1, 8'hB0);
    chk_log("t4 b3", base + 3, 0, 8'hA2);
    chk_log("t4 b4", base + 4, 0, 8'hA3);
    chk_log("t4 b5", base + 5, 0, 8'hA4);
    steps(50);
`ifdef UART_TX_ARB_TIMEOUT_EN
    chk("t4 grant after stall", bus.grant, 4'b0000);
`else
    chk("t4 grant held", bus.grant, 4'b0001);
`endif

    // reset while in WAIT with grant 0100; rrPtr must restart at 0
    hard_reset();
    busy_len = 10;
    base = log_id.size();
    push(2, 8'hC1, 1);
    wait_log(base + 1, 100, "t5 first");
    steps(15);
    push(2, 8'hC2, 1);
    begin
      int n = 0;
      while (!(bus.grant == 4'b0100 && bus.txBusy) && n < 100) begin
        step();
        n++;
      end
    end
    chk("t5 reach wait", (bus.grant == 4'b0100 && bus.txBusy), 1);
    #2 reset = 1'b1;
    #1;
    chk("t5 rst grant", bus.grant, 0);
    chk("t5 rst txValid", bus.txValid, 0);
    chk("t5 rst reqReady", bus.reqReady, 0);
    clear_queues();
    steps(2);
    #1 reset = 1'b0;
    base = log_id.size();
    push(0, 8'hD0, 1); push(3, 8'hD3, 1);
    wait_log(base + 2, 200, "t5 after");
    chk_log("t5 b0", base + 0, 0, 8'hD0);
    chk_log("t5 b1", base + 1, 3, 8'hD3);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // stalled owner times out after TO FETCH cycles
    hard_reset();
    busy_len = 1;
    base = log_id.size();
    clear_counters();
    push(2, 8'hE0, 0); push(3, 8'hE3, 1);
    wait_log(base + 2, 200, "t6 done");
    chk_log("t6 b0", base + 0, 2, 8'hE0);
    chk_log("t6 b1", base + 1, 3, 8'hE3);
    // one WAIT cycle with busy low plus TO stalled FETCH cycles
    chk("t6 stall cycles", c_stall, TO + 1);
`endif

    // random traffic against the model
    hard_reset();
    rnd_mode = 1; rnd_busy = 1;
    base = log_id.size();
    total = 0;
    for (int i = 0; i < N; i++) begin
      exp_d[i].delete();
      for (int m = 0; m < 25; m++) begin
        len = int'($urandom_range(1, 4));
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          push(i, b, k == len - 1);
          exp_d[i].push_back(b);
          total++;
        end
      end
    end
    wait_log(base + total, 20000, "rnd done");
    steps(20);
    for (int i = 0; i < N; i++) begin
      mism = 0; seen = 0;
      for (int k = base; k < log_id.size(); k++) begin
        if (log_id[k] == i) begin
          if (seen >= exp_d[i].size() || log_d[k] != exp_d[i][seen]) mism++;
          seen++;
        end
      end
      chk($sformatf("rnd req%0d count", i), seen, exp_d[i].size());
      chk($sformatf("rnd req%0d data", i), mism, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
